// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - MDUOp operation codes
//   - FSM state type
//   - result-width helper and opcode classification helpers
package mdu_pkg;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MADD  = 4'd5;
    localparam logic [3:0] MADDU = 4'd6;
    localparam logic [3:0] MSUB  = 4'd7;
    localparam logic [3:0] MSUBU = 4'd8;
    localparam logic [3:0] MTHI  = 4'd9;
    localparam logic [3:0] MTLO  = 4'd10;
    localparam logic [3:0] MFHI  = 4'd11;
    localparam logic [3:0] MFLO  = 4'd12;

    typedef enum logic {IDLE, BUSY} mdu_state_t;

    // Width of the {hi,lo} result for a given operand width.
    function automatic int res_w(input int w);
        return 2 * w;
    endfunction

    // Ops that run through the busy counter and commit {hi,lo} at the end.
    function automatic logic is_multi(input logic [3:0] op);
        return (op >= MULT) && (op <= MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational result generator for the multiply/divide unit.
// Ports:
//   op      : MDUOp code
//   a, b    : rs / rt operands
//   hi, lo  : current architectural HI/LO (accumulator input for madd/msub)
//   res     : {hi,lo} value the op would commit
//   dz      : divide op with b == 0 (commit must be suppressed)
module mdu_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [WIDTH-1:0]      hi,
    input  logic [WIDTH-1:0]      lo,
    output logic [2*WIDTH-1:0]    res,
    output logic                  dz
);

    localparam int RW = res_w(WIDTH);

    logic [RW-1:0]    acc, sprod, uprod;
    logic [WIDTH-1:0] bdiv, amag, bmag, qmag, rmag, sq, sr, uq, ur;

    always_comb begin
        acc   = {hi, lo};
        // Sign/zero extend to the full result width so the low RW bits of the
        // product are exact for both signed and unsigned interpretations.
        sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        dz    = is_div(op) && (b == '0);
        // Substitute a harmless divisor on divide-by-zero; result is discarded.
        bdiv  = dz ? WIDTH'(1) : b;

        // Signed divide through magnitudes: avoids the most-negative / -1
        // overflow in native signed division and yields lo=most-negative, hi=0.
        amag  = a[WIDTH-1]    ? -a    : a;
        bmag  = bdiv[WIDTH-1] ? -bdiv : bdiv;
        qmag  = amag / bmag;
        rmag  = amag % bmag;
        sq    = (a[WIDTH-1] ^ bdiv[WIDTH-1]) ? -qmag : qmag;
        sr    = a[WIDTH-1] ? -rmag : rmag;   // remainder follows dividend sign

        uq    = a / bdiv;
        ur    = a % bdiv;

        res   = acc;
        case (op)
            MULT:    res = sprod;
            MULTU:   res = uprod;
            DIV:     res = {sr, sq};
            DIVU:    res = {ur, uq};
            MADD:    res = acc + sprod;
            MADDU:   res = acc + uprod;
            MSUB:    res = acc - sprod;
            MSUBU:   res = acc - uprod;
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   start      : qualifies MDUOp; accepted when busy=0 and req=0
//   MDUOp      : operation code (mdu_pkg)
//   A, B       : rs / rt operands
//   req        : flush; discards a same-cycle start only
//   busy       : multi-cycle op in flight
//   hi, lo     : architectural HI/LO
//   out        : hi for MFHI, lo for MFLO, else 0 (combinational)
// The full result is computed at accept and held in a pending register; HI/LO
// only change on the final busy edge, so no partial value is ever visible.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam int RW   = res_w(WIDTH);
    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    pend_q, pend_d;
    logic             pdz_q, pdz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [RW-1:0]    core_res;
    logic             core_dz;
    logic             accept;

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .op  (MDUOp),
        .a   (A),
        .b   (B),
        .hi  (hi_q),
        .lo  (lo_q),
        .res (core_res),
        .dz  (core_dz)
    );

    assign busy   = (state_q == BUSY);
    assign accept = start & ~busy & ~req;
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_comb begin
        out = '0;
        if (MDUOp == MFHI)      out = hi_q;
        else if (MDUOp == MFLO) out = lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            pdz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pdz_q   <= pdz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        pdz_d   = pdz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_multi(MDUOp)) begin
                        // Operands are consumed here; the pending register
                        // carries the whole result through the busy window.
                        state_d = BUSY;
                        cnt_d   = is_div(MDUOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend_d  = core_res;
                        pdz_d   = core_dz;
                    end else if (MDUOp == MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == MTLO) begin
                        lo_d = A;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!pdz_q) begin
                        hi_d = pend_q[RW-1:WIDTH];
                        lo_d = pend_q[WIDTH-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk, reset, start, req, busy;
    logic [3:0]  MDUOp;
    logic [31:0] A, B, hi, lo, out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_hi, m_lo;
    int          n_chk, n_fail;

    mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
        .req(req), .busy(busy), .hi(hi), .lo(lo), .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic rules, using 64-bit integers.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl,
                                          output bit dz);
        longint      sa, sb, q, r;
        logic [63:0] sp, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sp = sa * sb;
        up = {32'd0, a} * {32'd0, b};
        dz = 0;
        model = hl;
        case (op)
            MULT:  model = sp;
            MULTU: model = up;
            MADD:  model = hl + sp;
            MADDU: model = hl + up;
            MSUB:  model = hl - sp;
            MSUBU: model = hl - up;
            DIV: begin
                if (b == 0) dz = 1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                if (b == 0) dz = 1;
                else model = {a % b, a / b};
            end
            default: model = hl;
        endcase
    endfunction

    // Monitor: count busy cycles, and on each busy fall pop and compare.
    initial begin
        int   cnt;
        bit   prev;
        exp_t e;
        cnt = 0;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                prev = 0;
            end else begin
                if (busy) cnt++;
                else if (prev) begin
                    if (sbq.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL commit: got unexpected commit expected none");
                    end else begin
                        e = sbq.pop_front();
                        chk("commit_hi", {32'd0, hi}, {32'd0, e.hi});
                        chk("commit_lo", {32'd0, lo}, {32'd0, e.lo});
                        chk("busy_cycles", 64'(cnt), 64'(e.cyc));
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, input bit track);
        logic [63:0] r;
        bit          dz;
        exp_t        e;
        @(posedge clk); #1;
        start = 1'b1; MDUOp = op; A = a; B = b; req = rq;
        if (!rq && track) begin
            if (op >= MULT && op <= MSUBU) begin
                r = model(op, a, b, {m_hi, m_lo}, dz);
                if (!dz) {m_hi, m_lo} = r;
                e.hi = m_hi; e.lo = m_lo;
                e.cyc = (op == DIV || op == DIVU) ? 10 : 5;
                sbq.push_back(e);
            end else if (op == MTHI) m_hi = a;
            else if (op == MTLO) m_lo = a;
        end
        @(posedge clk); #1;
        start = 1'b0; req = 1'b0; MDUOp = NOP;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        n_chk++; n_fail++;
        $display("FAIL wait_idle: got busy stuck expected idle within 200 cycles");
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({nm, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        n_chk = 0; n_fail = 0;
        m_hi = 0; m_lo = 0;
        reset = 1'b0; start = 1'b0; req = 1'b0; MDUOp = NOP; A = 0; B = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk_state("reset");
        @(posedge clk); #1 reset = 1'b1;

        // Reset mid-MULT aborts with no late commit
        issue(MTHI, 32'h55, 0, 0, 1);
        chk_state("mthi_pre");
        issue(MULT, 32'd7, 32'd9, 0, 0);  // returns in busy cycle 2
        chk("midop_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0; #1;
        m_hi = 0; m_lo = 0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk_state("abort");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_abort_busy", {63'd0, busy}, 64'd0);
            chk_state("post_abort");
        end

        // MULT / MULTU
        issue(MULT, 32'hFFFF_FFFE, 32'd3, 0, 1); wait_idle();
        chk("mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(MULTU, 32'hFFFF_FFFE, 32'd3, 0, 1); wait_idle();
        chk("multu", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // Signed divide incl. overflow corner
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 0, 1); wait_idle();
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1); wait_idle();
        chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        // Divide by zero leaves hi/lo
        issue(MTHI, 32'd5, 0, 0, 1);
        chk("mthi_busy", {63'd0, busy}, 64'd0);
        chk("mthi_val", {32'd0, hi}, 64'd5);
        issue(MTLO, 32'd9, 0, 0, 1);
        chk("mtlo_val", {32'd0, lo}, 64'd9);
        issue(DIVU, 32'd100, 32'd0, 0, 1); wait_idle();
        chk("divu_dz", {hi, lo}, {32'd5, 32'd9});

        // Accumulate carry/borrow across halves, back-to-back
        issue(MTHI, 32'd0, 0, 0, 1);
        issue(MTLO, 32'hFFFF_FFFF, 0, 0, 1);
        issue(MADDU, 32'd1, 32'd1, 0, 1); wait_idle();
        chk("maddu_carry", {hi, lo}, 64'h0000_0001_0000_0000);
        issue(MSUB, 32'd1, 32'd1, 0, 1); wait_idle();
        chk("msub_borrow", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

        // req cancels same-cycle start
        issue(MULT, 32'd123, 32'd456, 1, 1);
        chk("req_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("req_busy_later", {63'd0, busy}, 64'd0);
        chk_state("req");

        // start while busy is ignored
        issue(MULTU, 32'd1000, 32'd1000, 0, 1);
        start = 1'b1; MDUOp = MTHI; A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = NOP;
        wait_idle();
        chk_state("busy_ignore");

        // MFHI/MFLO combinational read
        MDUOp = MFLO; #1;
        chk("mflo_out", {32'd0, out}, {32'd0, m_lo});
        MDUOp = MFHI; #1;
        chk("mfhi_out", {32'd0, out}, {32'd0, m_hi});
        MDUOp = MULT; #1;
        chk("other_out", {32'd0, out}, 64'd0);
        MDUOp = NOP;

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 15));
            a = rnd32();
            b = rnd32();
            if (op == MFHI || op == MFLO) begin
                @(posedge clk); #1;
                MDUOp = op; #1;
                chk("rnd_out", {32'd0, out}, {32'd0, (op == MFHI) ? m_hi : m_lo});
                MDUOp = NOP;
            end else begin
                issue(op, a, b, 0, 1);
                if (op >= MULT && op <= MSUBU) wait_idle();
                else @(negedge clk);
                chk_state("rnd_state");
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core, sitting beside the single-cycle ALU in the EX stage.
- Owns the architectural HI/LO registers.
- Executes mult/multu/div/divu plus multiply-accumulate (madd/maddu/msub/msubu) with configurable latency.
- Exposes a busy/start handshake so the hazard unit can stall mfhi/mflo/mthi/mtlo and further MDU ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be >= 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  qualifies MDUOp for one cycle; the op is accepted only when busy=0 and req=0.
- MDUOp  in  4  operation code; see Decomposition.
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- req  in  1  exception/interrupt flush; a start in the same cycle is discarded.
- busy  out  1  a multi-cycle op is in flight.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- out  out  WIDTH  combinational read: hi when MDUOp=MFHI, lo when MDUOp=MFLO, else 0.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending result=0, state=IDLE.
- States:
  - IDLE -> BUSY on an accepted multi-cycle op.
  - BUSY -> IDLE when the counter reaches 1.
  - No other states.
- Accept condition: start & ~busy & ~req.
  - start while busy=1 is ignored; the hazard unit guarantees it never happens, and the bench checks that it is harmless.
- Accept edge for a multi-cycle op:
  - A and B are latched.
  - The 2*WIDTH pending result {P_hi,P_lo} is computed and stored.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - busy rises after the edge.
- busy stays 1 for exactly N cycles. On the Nth edge:
  - {hi,lo} <= pending result;
  - busy falls.
- hi/lo never show partial values while busy.
- Arithmetic:
  - MULT: signed A*B, 2*WIDTH product; hi=upper half, lo=lower half.
  - MULTU: unsigned A*B, same split.
  - MADD/MADDU: {hi,lo} + product (signed/unsigned product), modulo 2^(2*WIDTH). The {hi,lo} used is the value at the accept edge.
  - MSUB/MSUBU: {hi,lo} - product, modulo 2^(2*WIDTH).
  - DIV (signed): quotient truncates toward zero into lo; remainder carries the sign of A into hi.
  - DIV with A=most-negative and B=-1: lo=most-negative, hi=0, no trap.
  - DIVU: unsigned quotient into lo, remainder into hi.
  - Divide by zero (B=0, DIV or DIVU): the op is accepted and busy runs DIV_CYCLES, but hi/lo are left unchanged at commit.
- MTHI/MTLO:
  - When accepted: hi<=A (or lo<=A) on the accept edge; single cycle, busy stays 0.
- MFHI/MFLO/NOP: no state change; out is purely combinational from the current hi/lo.
- req:
  - Cancels only a same-cycle start.
  - An op already in BUSY always completes and commits, because its instruction has retired past EX.
- Reset asserted mid-operation aborts immediately: busy=0, hi/lo=0, and no commit occurs after release.
- Back-to-back: a new start is accepted in the first cycle with busy=0, i.e. the cycle after commit. A MADD issued then sees the committed hi/lo.
- Undefined MDUOp codes with start=1: no effect.

Decomposition:
- Shared package mdu_pkg:
  - MDUOp localparams: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10, MFHI=11, MFLO=12.
  - helper constant for the 2*WIDTH result width.
- One natural sub-module, mdu_core:
  - combinational 2*WIDTH result generator (multiply, accumulate, signed/unsigned divide, div-by-zero flag).
  - mdu_unit wraps it with the FSM, counter, pending register and HI/LO.

Test Plan:
1. Reset low mid-MULT (cycle 2 of 5) -> busy=0, hi=lo=0 immediately; after release, hi/lo stay 0 with no late commit.
2. start MULT A=0xFFFFFFFE(-2) B=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV A=-7 B=2 -> after 10 cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIV A=0x80000000 B=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload hi=5, lo=9 via MTHI/MTLO (busy stays 0, visible next cycle), then DIVU B=0 -> busy runs 10 cycles, hi=5, lo=9 unchanged.
5. MTHI 0, MTLO 0xFFFFFFFF, then MADDU A=1 B=1 -> hi=1, lo=0 (carry across halves). Then MSUB A=1 B=1 -> hi=0, lo=0xFFFFFFFF.
6. start MULT with req=1 -> busy never rises, hi/lo unchanged. start while busy=1 -> ignored, original op commits. MFLO with start=0 -> out=lo combinationally.
